// File: rtl/axis_sample_if.sv
// AXI-Stream sample bus between the sample source and the biquad chain.
interface axis_sample_if #(
    parameter int unsigned DATA_W = 16
) ();
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_sample_source.sv
// Buffers ADC sample strobes in a small FIFO and replays them as a framed
// AXI-Stream with a registered output stage and sticky overflow reporting.
module axis_sample_source #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned FRAME_LEN = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    axis_sample_if.master            m_axis,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     ovf,
    input  logic                     ovf_clr,
    output logic [15:0]              drop_cnt
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned FILL_W = ADDR_W + 1;
    localparam int unsigned CNT_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  beat_q;
    logic              tvalid_q;
    logic              tlast_q;
    logic [DATA_W-1:0] tdata_q;

    logic xfer;
    logic pop;
    logic full;
    logic wr;
    logic drop;
    logic beat_last;

    assign xfer      = tvalid_q & m_axis.tready;
    assign full      = (fill == FILL_W'(DEPTH));
    // Pop whenever the output register is free now or frees up at this edge.
    assign pop       = (fill != '0) & (~tvalid_q | xfer);
    assign wr        = en & in_valid & (~full | pop);
    assign drop      = en & in_valid & full & ~pop;
    assign beat_last = (beat_q == CNT_W'(FRAME_LEN - 1));

    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tlast  = tlast_q;

    // Sample storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            if (wr && !pop) begin
                fill <= fill + FILL_W'(1);
            end else if (pop && !wr) begin
                fill <= fill - FILL_W'(1);
            end
        end
    end

    // Output register: EMPTY/HOLD is just tvalid_q; tlast follows load order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            beat_q   <= '0;
        end else begin
            if (pop) begin
                tvalid_q <= 1'b1;
                tdata_q  <= mem[rd_ptr];
                tlast_q  <= beat_last;
                beat_q   <= beat_last ? '0 : beat_q + CNT_W'(1);
            end else if (xfer) begin
                tvalid_q <= 1'b0;
            end
        end
    end

    // Sticky overflow and saturating drop counter; clear beats a same-cycle drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (ovf_clr) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            ovf <= 1'b1;
            if (drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_axis_sample_source.sv
// Scoreboard bench for axis_sample_source: accepted samples are queued at
// drive time and matched against every completed output beat.
module tb_axis_sample_source;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned DEPTH     = 8;
    localparam int unsigned FRAME_LEN = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [3:0]        fill;
    logic              ovf;
    logic              ovf_clr;
    logic [15:0]       drop_cnt;

    axis_sample_if #(.DATA_W(DATA_W)) axis ();

    axis_sample_source #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid),
        .in_data(in_data), .m_axis(axis), .fill(fill), .ovf(ovf),
        .ovf_clr(ovf_clr), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int                n_checks = 0;
    int                n_errors = 0;
    logic [DATA_W-1:0] exp_q[$];
    int                beat_n = 0;
    logic              stall_prev = 1'b0;
    logic [DATA_W-1:0] hold_data;
    logic              hold_last;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Inputs are stable between negedge and the next posedge, so a beat seen
    // here with tvalid & tready completes on the coming edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_tvalid", 32'(axis.tvalid), 32'd1);
                check("stall_tdata", 32'(axis.tdata), 32'(hold_data));
                check("stall_tlast", 32'(axis.tlast), 32'(hold_last));
            end
            if (axis.tvalid && axis.tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(axis.tdata), 32'hDEAD_BEEF);
                end else begin
                    beat_n++;
                    check("beat_data", 32'(axis.tdata), 32'(exp_q.pop_front()));
                    check("beat_tlast", 32'(axis.tlast), 32'((beat_n % FRAME_LEN) == 0));
                end
            end
            stall_prev = axis.tvalid && !axis.tready;
            hold_data  = axis.tdata;
            hold_last  = axis.tlast;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input bit accept);
        in_valid = 1'b1;
        in_data  = d;
        if (accept) exp_q.push_back(d);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles, input bit rnd);
        int n = 0;
        while ((exp_q.size() != 0 || axis.tvalid) && n < max_cycles) begin
            if (rnd) axis.tready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        axis.tready = 1'b1;
        check("drain_timeout", 32'(n < max_cycles), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; in_data = '0; ovf_clr = 1'b0;
        axis.tready = 1'b1;
        #22;
        check("rst_tvalid", 32'(axis.tvalid), 32'd0);
        check("rst_tdata", 32'(axis.tdata), 32'd0);
        check("rst_tlast", 32'(axis.tlast), 32'd0);
        check("rst_fill", 32'(fill), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        rst_n = 1'b1;
        repeat (8) step();

        // Single sample: two-cycle latency, one cycle of tvalid.
        send(16'h1234, 1'b1);
        check("single_wr_tvalid", 32'(axis.tvalid), 32'd0);
        check("single_wr_fill", 32'(fill), 32'd1);
        step();
        check("single_ld_tvalid", 32'(axis.tvalid), 32'd1);
        check("single_ld_tdata", 32'(axis.tdata), 32'h1234);
        check("single_ld_fill", 32'(fill), 32'd0);
        step();
        check("single_done_tvalid", 32'(axis.tvalid), 32'd0);

        // Streaming at full rate.
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(i);
            exp_q.push_back(DATA_W'(i));
            step();
            check("stream_fill_le1", 32'(fill <= 4'd1), 32'd1);
        end
        in_valid = 1'b0;
        wait_drain(20, 1'b0);
        check("stream_ovf", 32'(ovf), 32'd0);

        // Backpressure: 1 held in the output stage, 2..9 fill the FIFO, 10..12 drop.
        axis.tready = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            send(DATA_W'(i), i <= 9);
        end
        check("bp_fill", 32'(fill), 32'd8);
        check("bp_ovf", 32'(ovf), 32'd1);
        check("bp_drop", 32'(drop_cnt), 32'd3);
        check("bp_tvalid", 32'(axis.tvalid), 32'd1);
        check("bp_tdata", 32'(axis.tdata), 32'd1);

        // Disabled capture ignores strobes entirely.
        en = 1'b0;
        repeat (3) send(16'hBAD0, 1'b0);
        en = 1'b1;
        check("en0_fill", 32'(fill), 32'd8);
        check("en0_drop", 32'(drop_cnt), 32'd3);

        // Clear coincident with a drop: clear wins.
        ovf_clr = 1'b1;
        send(16'hBAD1, 1'b0);
        ovf_clr = 1'b0;
        check("clr_ovf", 32'(ovf), 32'd0);
        check("clr_drop", 32'(drop_cnt), 32'd0);

        // Full FIFO with a simultaneous pop accepts the sample.
        axis.tready = 1'b1;
        send(16'd13, 1'b1);
        axis.tready = 1'b0;
        check("fullpop_fill", 32'(fill), 32'd8);
        check("fullpop_drop", 32'(drop_cnt), 32'd0);
        check("fullpop_tdata", 32'(axis.tdata), 32'd2);

        axis.tready = 1'b1;
        wait_drain(30, 1'b0);
        check("drain_tvalid", 32'(axis.tvalid), 32'd0);
        check("drain_fill", 32'(fill), 32'd0);

        // Reset mid-stream discards buffered data and restarts framing.
        axis.tready = 1'b0;
        for (int i = 0; i < 5; i++) send(DATA_W'(16'h500 + i), 1'b0);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        beat_n = 0;
        #1;
        check("midrst_tvalid", 32'(axis.tvalid), 32'd0);
        check("midrst_fill", 32'(fill), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Framing under random stalls: tlast on beats 4 and 8.
        for (int i = 0; i < 10; i++) begin
            axis.tready = ((i % 2) == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            send(DATA_W'(100 + i), 1'b1);
        end
        wait_drain(60, 1'b1);
        check("frame_beats", 32'(beat_n), 32'd10);
        check("frame_ovf", 32'(ovf), 32'd0);

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/axis_sample_source.md
Name: axis_sample_source

Overview:
- AXI-Stream master that feeds sample streams into the biquad filter chain (the filter's s_axis_tvalid/s_axis_tdata side).
- Accepts single-cycle sample strobes from the ADC capture logic and buffers them in a small FIFO.
- Drives a fully compliant valid/ready stream with a tlast frame marker.
- Reports overflow when the downstream stalls longer than the FIFO can absorb.

Parameters:
- DATA_W, 16, sample width; signed two's complement, passed through unmodified.
- DEPTH, 8, FIFO depth in words; power of 2, minimum 2.
- FRAME_LEN, 256, beats per frame; tlast marks beat FRAME_LEN; minimum 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  capture enable; when low, incoming samples are ignored.
- in_valid  in  1  single-cycle sample strobe from capture logic.
- in_data  in  DATA_W  sample, valid when in_valid=1.
- m_axis_tvalid  out  1  output word valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  DATA_W  output sample.
- m_axis_tlast  out  1  last beat of frame.
- fill  out  clog2(DEPTH)+1  FIFO occupancy; excludes the output register.
- ovf  out  1  sticky overflow flag.
- ovf_clr  in  1  synchronous clear for ovf and drop_cnt.
- drop_cnt  out  16  count of dropped samples, saturating at 65535.

Behaviour:
- Async reset, active-low, clock clk.
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, fill=0, ovf=0, drop_cnt=0. FIFO pointers and frame counter are set to 0.
- Reset asserted mid-stream: all buffered data is discarded and the frame counter restarts at beat 1.
- Handshake: a beat transfers on the rising edge where m_axis_tvalid & m_axis_tready are both 1.
  - Once m_axis_tvalid is asserted, it, m_axis_tdata and m_axis_tlast hold stable until the transfer.
  - m_axis_tvalid never depends combinationally on m_axis_tready.
- Datapath: FIFO followed by a registered output stage; all outputs come straight from registers.
  - The output register loads from the FIFO head when FIFO is non-empty AND (output register empty OR a transfer occurs this cycle).
  - Each transfer followed by a non-empty FIFO gives back-to-back beats, so full throughput is 1 beat/cycle.
- Latency: in_valid at cycle N with FIFO and output register empty -> data written at edge N, loaded at edge N+1, m_axis_tvalid=1 during cycle N+2.
- Write acceptance: a sample is written when en=1, in_valid=1, and (fill<DEPTH OR an output-register load pops the FIFO this cycle).
  - A simultaneous write and pop leaves fill unchanged.
- Overflow: en=1, in_valid=1, fill==DEPTH and no pop this cycle -> sample dropped, ovf set, drop_cnt incremented (saturating).
  - ovf_clr=1 clears ovf and drop_cnt next edge. If a drop occurs in the same cycle as ovf_clr, the clear wins.
- en=0: samples are ignored and not counted as drops; buffered words continue to drain normally.
- Pointers: ADDR_W=clog2(DEPTH) wrapping read/write pointers plus a separate occupancy counter. Full is fill==DEPTH, empty is fill==0.
- Framing:
  - The beat counter increments on each transfer; m_axis_tlast=1 when the loaded word is beat FRAME_LEN.
  - The counter wraps to beat 1 after the tlast transfer.
  - FRAME_LEN=1 makes every beat tlast.
  - tlast is computed when the output register loads, from the count of words loaded so far, not from transfers pending.
- No internal state machine beyond the output-register valid bit. The states are EMPTY (tvalid=0) and HOLD (tvalid=1):
  - EMPTY->HOLD on load.
  - HOLD->EMPTY on a transfer with FIFO empty.
  - HOLD->HOLD on a transfer with FIFO non-empty (reload), or while stalled.

Test Plan:
- Single sample: tready=1, one in_valid with in_data=16'h1234 at cycle 10 -> tvalid=1, tdata=16'h1234 in cycle 12 only; fill returns to 0.
- Streaming: tready=1, in_valid every cycle with data 0..99 -> 100 beats in order, 1 per cycle after 2-cycle latency; ovf=0; fill<=1.
- Backpressure: DEPTH=8, tready=0, 12 samples 1..12 -> tvalid held with tdata=1; fill=8; samples 10..12 dropped; ovf=1; drop_cnt=3. Release tready -> beats 1..9 out, then tvalid=0.
- Full with simultaneous pop: fill=8, tready pulsed 1 for one cycle in the same cycle as in_valid -> sample accepted, fill stays 8, drop_cnt unchanged.
- Framing: FRAME_LEN=4, stream 10 beats with random tready stalls -> tlast on beats 4 and 8 only, stable through stalls.
- en=0 plus ovf_clr: en=0 while in_valid pulses -> no writes and no drops. ovf_clr asserted -> ovf=0, drop_cnt=0 next cycle. Reset mid-stream -> tvalid=0 immediately; the next frame's first beat is beat 1.
